// File: rtl/alien_formation_pkg.sv
// ---------------------------------------------------------------------------
// alien_formation_pkg
// Screen constants, formation defaults and state encoding shared by the
// invader formation block and its cell lookup.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alien_formation_pkg;

  // Visible window in renderer counter space (porches included)
  localparam int HBP = 144;
  localparam int HFP = 784;
  localparam int VBP = 31;
  localparam int VFP = 511;

  // Formation defaults
  localparam int DEF_COLS        = 8;
  localparam int DEF_ROWS        = 4;
  localparam int DEF_COL_SHIFT   = 5;
  localparam int DEF_ROW_SHIFT   = 5;
  localparam int DEF_ALIEN_W     = 16;
  localparam int DEF_ALIEN_H     = 16;
  localparam int DEF_START_X     = 160;
  localparam int DEF_START_Y     = 63;
  localparam int DEF_LAND_Y      = 486;
  localparam int DEF_STEP_X      = 4;
  localparam int DEF_STEP_Y      = 16;
  localparam int DEF_SPEED_SHIFT = 3;

  typedef enum logic [1:0] {
    ST_MARCH   = 2'd0,
    ST_DESCEND = 2'd1,
    ST_CLEARED = 2'd2,
    ST_LANDED  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alien_formation_grid_cell_lookup.sv
// ---------------------------------------------------------------------------
// grid_cell_lookup
// Maps a point to its formation cell: reports whether the point lies on a
// sprite footprint, the linear cell index, and whether that alien is alive.
// Purely combinational.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module grid_cell_lookup
  import alien_formation_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int COL_SHIFT = DEF_COL_SHIFT,
  parameter int ROW_SHIFT = DEF_ROW_SHIFT,
  parameter int ALIEN_W   = DEF_ALIEN_W,
  parameter int ALIEN_H   = DEF_ALIEN_H,
  parameter int N         = COLS * ROWS,
  parameter int IDX_W     = $clog2(N)
) (
  input  logic [9:0]       pt_x_i,
  input  logic [9:0]       pt_y_i,
  input  logic [9:0]       org_x_i,
  input  logic [9:0]       org_y_i,
  input  logic [N-1:0]     alive_mask_i,
  output logic             in_cell_o,
  output logic             alive_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [10:0] c_col_mask = 11'((1 << COL_SHIFT) - 1);
  localparam logic [10:0] c_row_mask = 11'((1 << ROW_SHIFT) - 1);

  logic [10:0] w_rx;
  logic [10:0] w_ry;
  logic [10:0] w_col;
  logic [10:0] w_row;
  logic        w_past_origin;
  logic        w_in_grid;
  logic        w_on_sprite;

  // Offsets are 11-bit; a negative offset is rejected by w_past_origin
  assign w_rx          = {1'b0, pt_x_i} - {1'b0, org_x_i};
  assign w_ry          = {1'b0, pt_y_i} - {1'b0, org_y_i};
  assign w_col         = w_rx >> COL_SHIFT;
  assign w_row         = w_ry >> ROW_SHIFT;
  assign w_past_origin = (pt_x_i >= org_x_i) && (pt_y_i >= org_y_i);
  assign w_in_grid     = (w_col < 11'(COLS)) && (w_row < 11'(ROWS));
  assign w_on_sprite   = ((w_rx & c_col_mask) < 11'(ALIEN_W)) &&
                         ((w_ry & c_row_mask) < 11'(ALIEN_H));

  assign in_cell_o = w_past_origin && w_in_grid && w_on_sprite;
  assign idx_o     = in_cell_o ? IDX_W'(32'(w_row) * COLS + 32'(w_col)) : '0;
  assign alive_o   = in_cell_o && alive_mask_i[idx_o];

endmodule

`default_nettype wire

// File: rtl/alien_formation.sv
// ---------------------------------------------------------------------------
// alien_formation
// Invader grid owner: alive mask, marching origin, descent/landing,
// bullet-vs-alien hit detection and a registered per-pixel alien bit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alien_formation
  import alien_formation_pkg::*;
#(
  parameter int COLS        = DEF_COLS,
  parameter int ROWS        = DEF_ROWS,
  parameter int COL_SHIFT   = DEF_COL_SHIFT,
  parameter int ROW_SHIFT   = DEF_ROW_SHIFT,
  parameter int ALIEN_W     = DEF_ALIEN_W,
  parameter int ALIEN_H     = DEF_ALIEN_H,
  parameter int START_X     = DEF_START_X,
  parameter int START_Y     = DEF_START_Y,
  parameter int X_MIN       = HBP,
  parameter int X_MAX       = HFP,
  parameter int LAND_Y      = DEF_LAND_Y,
  parameter int STEP_X      = DEF_STEP_X,
  parameter int STEP_Y      = DEF_STEP_Y,
  parameter int SPEED_SHIFT = DEF_SPEED_SHIFT,
  parameter int N           = COLS * ROWS,
  parameter int IDX_W       = $clog2(N),
  parameter int CNT_W       = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_tick,
  input  logic             restart,
  input  logic             bullet_valid,
  input  logic [9:0]       bullet_x,
  input  logic [9:0]       bullet_y,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  output logic             alien_px,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [N-1:0]     alive_mask,
  output logic [CNT_W-1:0] alive_count,
  output logic [9:0]       origin_x,
  output logic [9:0]       origin_y,
  output logic             cleared,
  output logic             landed
);

  state_e           state_q, state_d;
  logic [9:0]       origin_x_q, origin_x_d;
  logic [9:0]       origin_y_q, origin_y_d;
  logic             dir_right_q, dir_right_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     alive_q, alive_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic             px_q, px_d;

  logic             w_bul_in_cell, w_bul_alive;
  logic [IDX_W-1:0] w_bul_idx;
  logic             w_pix_in_cell, w_pix_alive;
  logic [IDX_W-1:0] w_pix_idx;
  logic             w_unused_pix;

  logic [COLS-1:0]  w_col_live;
  logic [ROWS-1:0]  w_row_live;
  logic [10:0]      w_r_col, w_l_col, w_b_row;
  logic [10:0]      w_right_sum, w_left_sum, w_new_y, w_land_sum;
  logic [10:0]      w_x_inc, w_x_dec;
  logic             w_right_block, w_left_block, w_edge, w_land;
  logic [CNT_W-1:0] w_period_raw, w_period;
  logic [CNT_W:0]   w_tick_next;
  logic             w_active, w_period_done, w_move, w_hit;

  grid_cell_lookup #(
    .COLS(COLS), .ROWS(ROWS), .COL_SHIFT(COL_SHIFT), .ROW_SHIFT(ROW_SHIFT),
    .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .N(N), .IDX_W(IDX_W)
  ) u_bullet_lookup (
    .pt_x_i(bullet_x), .pt_y_i(bullet_y),
    .org_x_i(origin_x_q), .org_y_i(origin_y_q), .alive_mask_i(alive_q),
    .in_cell_o(w_bul_in_cell), .alive_o(w_bul_alive), .idx_o(w_bul_idx)
  );

  grid_cell_lookup #(
    .COLS(COLS), .ROWS(ROWS), .COL_SHIFT(COL_SHIFT), .ROW_SHIFT(ROW_SHIFT),
    .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .N(N), .IDX_W(IDX_W)
  ) u_pixel_lookup (
    .pt_x_i(pix_x), .pt_y_i(pix_y),
    .org_x_i(origin_x_q), .org_y_i(origin_y_q), .alive_mask_i(alive_q),
    .in_cell_o(w_pix_in_cell), .alive_o(w_pix_alive), .idx_o(w_pix_idx)
  );

  // The pixel path needs only the live/sprite bit, not the cell index
  assign w_unused_pix = ^w_pix_idx;

  // Column/row occupancy and the extreme live column/row indices
  always_comb begin
    w_col_live = '0;
    w_row_live = '0;
    w_r_col    = '0;
    w_l_col    = '0;
    w_b_row    = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_q[r*COLS + c]) begin
          w_col_live[c] = 1'b1;
          w_row_live[r] = 1'b1;
        end
      end
    end
    for (int c = 0; c < COLS; c++) begin
      if (w_col_live[c]) w_r_col = 11'(c);
    end
    for (int c = COLS - 1; c >= 0; c--) begin
      if (w_col_live[c]) w_l_col = 11'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (w_row_live[r]) w_b_row = 11'(r);
    end
  end

  // Edge and landing tests are done at 11 bits so the sums never wrap
  assign w_right_sum   = {1'b0, origin_x_q} + (w_r_col << COL_SHIFT) +
                         11'(ALIEN_W) + 11'(STEP_X);
  assign w_left_sum    = {1'b0, origin_x_q} + (w_l_col << COL_SHIFT);
  assign w_right_block = w_right_sum > 11'(X_MAX);
  assign w_left_block  = w_left_sum < 11'(X_MIN + STEP_X);
  assign w_edge        = dir_right_q ? w_right_block : w_left_block;
  assign w_new_y       = {1'b0, origin_y_q} + 11'(STEP_Y);
  assign w_land_sum    = w_new_y + (w_b_row << ROW_SHIFT) + 11'(ALIEN_H);
  assign w_land        = w_land_sum >= 11'(LAND_Y);
  assign w_x_inc       = {1'b0, origin_x_q} + 11'(STEP_X);
  assign w_x_dec       = {1'b0, origin_x_q} - 11'(STEP_X);

  // Move period shrinks as the formation thins, never below one tick
  assign w_period_raw  = count_q >> SPEED_SHIFT;
  assign w_period      = (w_period_raw == '0) ? CNT_W'(1) : w_period_raw;
  assign w_tick_next   = {1'b0, tick_q} + {{CNT_W{1'b0}}, 1'b1};
  assign w_period_done = w_tick_next >= {1'b0, w_period};
  assign w_active      = (state_q == ST_MARCH) || (state_q == ST_DESCEND);
  assign w_move        = w_active && game_tick && w_period_done && (count_q != '0);
  assign w_hit         = bullet_valid && w_active && w_bul_in_cell && w_bul_alive;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_MARCH;
    else      state_q <= state_d;
  end

  // FSM next-state: clearing wins over movement; landing checked on descent
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_MARCH;
    end else begin
      case (state_q)
        ST_MARCH: begin
          if (count_q == '0)         state_d = ST_CLEARED;
          else if (w_move && w_edge) state_d = ST_DESCEND;
        end
        ST_DESCEND: begin
          if (count_q == '0) state_d = ST_CLEARED;
          else if (w_move)   state_d = w_land ? ST_LANDED : ST_MARCH;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    cleared = (state_q == ST_CLEARED);
    landed  = (state_q == ST_LANDED);
  end

  // Datapath next-state: tick counter, origin, direction, hits and pixel bit
  always_comb begin
    origin_x_d  = origin_x_q;
    origin_y_d  = origin_y_q;
    dir_right_d = dir_right_q;
    tick_d      = tick_q;
    count_d     = count_q;
    alive_d     = alive_q;
    hit_d       = 1'b0;
    hit_idx_d   = hit_idx_q;
    px_d        = w_pix_alive && (state_q != ST_CLEARED);
    if (restart) begin
      origin_x_d  = 10'(START_X);
      origin_y_d  = 10'(START_Y);
      dir_right_d = 1'b1;
      tick_d      = '0;
      count_d     = CNT_W'(N);
      alive_d     = '1;
      hit_idx_d   = '0;
      px_d        = 1'b0;
    end else begin
      if (w_active && game_tick) begin
        tick_d = w_period_done ? '0 : w_tick_next[CNT_W-1:0];
      end
      if (w_move) begin
        if (state_q == ST_MARCH) begin
          if (!w_edge) origin_x_d = dir_right_q ? w_x_inc[9:0] : w_x_dec[9:0];
        end else begin
          origin_y_d  = w_new_y[9:0];
          dir_right_d = ~dir_right_q;
        end
      end
      // Hit uses the pre-move origin; both updates land on the same edge
      if (w_hit) begin
        alive_d[w_bul_idx] = 1'b0;
        count_d            = count_q - CNT_W'(1);
        hit_d              = 1'b1;
        hit_idx_d          = w_bul_idx;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      origin_x_q  <= 10'(START_X);
      origin_y_q  <= 10'(START_Y);
      dir_right_q <= 1'b1;
      tick_q      <= '0;
      count_q     <= CNT_W'(N);
      alive_q     <= '1;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      px_q        <= 1'b0;
    end else begin
      origin_x_q  <= origin_x_d;
      origin_y_q  <= origin_y_d;
      dir_right_q <= dir_right_d;
      tick_q      <= tick_d;
      count_q     <= count_d;
      alive_q     <= alive_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      px_q        <= px_d;
    end
  end

  assign alien_px    = px_q;
  assign hit         = hit_q;
  assign hit_idx     = hit_idx_q;
  assign alive_mask  = alive_q;
  assign alive_count = count_q;
  assign origin_x    = origin_x_q;
  assign origin_y    = origin_y_q;

endmodule

`default_nettype wire
